// File: rtl/fetch_pair_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pair_ctrl_pkg
// Description : Shared types and constants for the dual-issue front-end
//               sequencer: FSM state enum, PC width, slot encoding and the
//               one-hot PC-source select bit positions.
// Revision    : 1.0 - initial release
// ============================================================================
package fetch_pair_ctrl_pkg;

    localparam int PC_W = 8;
    typedef logic [PC_W-1:0] pc_t;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        STALL  = 2'd1,
        REFILL = 2'd2
    } fsm_state_t;

    // Slot encoding used by jump_d_slot
    localparam logic SLOT1 = 1'b0;
    localparam logic SLOT2 = 1'b1;

    // One-hot select bit positions for pc_next_mux
    localparam int SEL_W     = 5;
    localparam int SEL_SEQ   = 0;
    localparam int SEL_PRED1 = 1;
    localparam int SEL_PRED2 = 2;
    localparam int SEL_JUMP  = 3;
    localparam int SEL_REDIR = 4;

    // Sequential fetch advances over both slots; wraps at 8 bits
    function automatic pc_t pc_plus2(input pc_t pc);
        return pc + pc_t'(2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_pair_ctrl_pc_next_mux.sv
`default_nettype none
// ============================================================================
// Module      : pc_next_mux
// Description : Pure combinational next-PC selector. AND-OR mux driven by a
//               one-hot select from the sequencer FSM.
// Ports       : sel      - one-hot source select (SEL_* bit positions)
//               pc_seq   - sequential PC (pcF + 2)
//               pc_pred1 - slot-1 predicted target
//               pc_pred2 - slot-2 predicted target
//               pc_jump  - decode jump target
//               pc_redir - execute redirect target
//               pc_out   - selected next PC
// Revision    : 1.0 - initial release
// ============================================================================
module pc_next_mux
    import fetch_pair_ctrl_pkg::*;
(
    input  logic [SEL_W-1:0] sel,
    input  logic [PC_W-1:0]  pc_seq,
    input  logic [PC_W-1:0]  pc_pred1,
    input  logic [PC_W-1:0]  pc_pred2,
    input  logic [PC_W-1:0]  pc_jump,
    input  logic [PC_W-1:0]  pc_redir,
    output logic [PC_W-1:0]  pc_out
);

    always_comb begin
        pc_out = '0;
        if (sel[SEL_SEQ])   pc_out = pc_out | pc_seq;
        if (sel[SEL_PRED1]) pc_out = pc_out | pc_pred1;
        if (sel[SEL_PRED2]) pc_out = pc_out | pc_pred2;
        if (sel[SEL_JUMP])  pc_out = pc_out | pc_jump;
        if (sel[SEL_REDIR]) pc_out = pc_out | pc_redir;
    end

endmodule
`default_nettype wire

// File: rtl/fetch_pair_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : fetch_pair_ctrl
// Description : Front-end sequencer for the dual-issue core. Arbitrates
//               execute redirects, decode jumps, decode stalls and fetch
//               predictions; drives stall/flush of the fetch->decode-1
//               register and selects the next fetch PC. Inserts IMEM_LAT
//               refill bubbles after a redirect or jump.
// Ports       : clk, reset (async, active-low)
//               pcF, predictionF_1/2, pcBranchF, pcBranchF_inst2 - fetch
//               stall_req_d, jump_d, jump_d_slot, jump_d_target  - decode
//               redirect_e, redirect_e_target                     - execute
//               stall_outer, flush_F_1/2, flush_D_1/2             - pipe ctl
//               pc_en, pc_next                                    - PC reg
//               stall_timeout                                     - debug
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_pair_ctrl
    import fetch_pair_ctrl_pkg::*;
#(
    parameter int IMEM_LAT  = 1,
    parameter int MAX_STALL = 15
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [PC_W-1:0] pcF,
    input  logic            predictionF_1,
    input  logic            predictionF_2,
    input  logic [PC_W-1:0] pcBranchF,
    input  logic [PC_W-1:0] pcBranchF_inst2,
    input  logic            stall_req_d,
    input  logic            jump_d,
    input  logic            jump_d_slot,
    input  logic [PC_W-1:0] jump_d_target,
    input  logic            redirect_e,
    input  logic [PC_W-1:0] redirect_e_target,
    output logic            stall_outer,
    output logic            flush_F_1,
    output logic            flush_F_2,
    output logic            flush_D_1,
    output logic            flush_D_2,
    output logic            pc_en,
    output logic [PC_W-1:0] pc_next,
    output logic            stall_timeout
);

    localparam int               STALL_W       = $clog2(MAX_STALL + 1);
    localparam logic [STALL_W-1:0] c_stall_max   = STALL_W'(MAX_STALL);
    localparam logic [1:0]       c_refill_load = 2'(IMEM_LAT);

    fsm_state_t         r_state;
    fsm_state_t         w_state_nxt;
    logic [STALL_W-1:0] r_stall_cnt;
    logic [STALL_W-1:0] w_stall_cnt_nxt;
    logic [1:0]         r_refill_cnt;
    logic [1:0]         w_refill_cnt_nxt;

    logic               w_in_refill;
    logic               w_redir;
    logic               w_jump;
    logic               w_hold;
    logic               w_refill;
    logic               w_fetch_ok;
    logic               w_pred1;
    logic               w_pred2;
    logic [SEL_W-1:0]   w_pc_sel;

    // Event decode in priority order. reset is active-low, so gating with it
    // masks every event while reset is held: outputs fall back to the idle
    // sequential-fetch values immediately on assertion.
    assign w_in_refill = (r_state == REFILL);
    assign w_redir     = reset & redirect_e;
    assign w_jump      = reset & jump_d & ~w_redir;
    // Only bubbles are in flight during refill, so a decode hold is moot there
    assign w_hold      = reset & stall_req_d & ~w_redir & ~w_jump & ~w_in_refill;
    assign w_refill    = w_in_refill & ~w_redir & ~w_jump;
    assign w_fetch_ok  = reset & ~w_redir & ~w_jump & ~w_hold & ~w_in_refill;
    assign w_pred1     = w_fetch_ok & predictionF_1;
    assign w_pred2     = w_fetch_ok & ~predictionF_1 & predictionF_2;

    // ------------------------------------------------------------------
    // State and counter registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= RUN;
            r_stall_cnt  <= '0;
            r_refill_cnt <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_stall_cnt  <= w_stall_cnt_nxt;
            r_refill_cnt <= w_refill_cnt_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt      = RUN;
        w_stall_cnt_nxt  = '0;
        w_refill_cnt_nxt = '0;
        if (w_redir || w_jump) begin
            // A redirect arriving mid-refill simply restarts the bubble count
            w_state_nxt      = REFILL;
            w_refill_cnt_nxt = c_refill_load;
        end else if (w_hold) begin
            w_state_nxt     = STALL;
            w_stall_cnt_nxt = (r_stall_cnt == c_stall_max) ? r_stall_cnt
                                                           : r_stall_cnt + 1'b1;
        end else if (w_refill) begin
            if (r_refill_cnt > 2'd1) begin
                w_state_nxt      = REFILL;
                w_refill_cnt_nxt = r_refill_cnt - 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        stall_outer   = w_hold;
        pc_en         = ~w_hold;
        // Flush_F and stall are mutually exclusive by construction: w_hold
        // excludes redirect, jump and refill.
        flush_F_1     = w_redir | w_jump | w_refill;
        // Slot 2 is wrong-path behind a taken slot-1 prediction
        flush_F_2     = w_redir | w_jump | w_refill | w_pred1;
        flush_D_1     = w_redir;
        // A slot-1 jump kills its slot-2 companion; a slot-2 jump keeps slot 1
        flush_D_2     = w_redir | (w_jump & (jump_d_slot == SLOT1));
        stall_timeout = w_hold & (r_stall_cnt == c_stall_max);

        w_pc_sel            = '0;
        w_pc_sel[SEL_REDIR] = w_redir;
        w_pc_sel[SEL_JUMP]  = w_jump;
        w_pc_sel[SEL_PRED1] = w_pred1;
        w_pc_sel[SEL_PRED2] = w_pred2;
        w_pc_sel[SEL_SEQ]   = ~(w_redir | w_jump | w_pred1 | w_pred2);
    end

    pc_next_mux u_pc_next_mux (
        .sel      (w_pc_sel),
        .pc_seq   (pc_plus2(pcF)),
        .pc_pred1 (pcBranchF),
        .pc_pred2 (pcBranchF_inst2),
        .pc_jump  (jump_d_target),
        .pc_redir (redirect_e_target),
        .pc_out   (pc_next)
    );

endmodule
`default_nettype wire

// File: tb/tb_fetch_pair_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_pair_ctrl
// Description : Self-checking bench for fetch_pair_ctrl. A cycle-level model
//               (bubble count remaining, consecutive stall count) predicts
//               every output each cycle; directed vectors add literal checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_fetch_pair_ctrl;

    localparam int LAT  = 1;
    localparam int MAXS = 15;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] pcF = 8'h10;
    logic       predictionF_1 = 1'b0, predictionF_2 = 1'b0;
    logic [7:0] pcBranchF = 8'h00, pcBranchF_inst2 = 8'h00;
    logic       stall_req_d = 1'b0, jump_d = 1'b0, jump_d_slot = 1'b0;
    logic [7:0] jump_d_target = 8'h00;
    logic       redirect_e = 1'b0;
    logic [7:0] redirect_e_target = 8'h00;
    logic       stall_outer, flush_F_1, flush_F_2, flush_D_1, flush_D_2;
    logic       pc_en, stall_timeout;
    logic [7:0] pc_next;

    int n_checks = 0;
    int n_fail   = 0;

    fetch_pair_ctrl #(.IMEM_LAT(LAT), .MAX_STALL(MAXS)) dut (
        .clk               (clk),
        .reset             (reset),
        .pcF               (pcF),
        .predictionF_1     (predictionF_1),
        .predictionF_2     (predictionF_2),
        .pcBranchF         (pcBranchF),
        .pcBranchF_inst2   (pcBranchF_inst2),
        .stall_req_d       (stall_req_d),
        .jump_d            (jump_d),
        .jump_d_slot       (jump_d_slot),
        .jump_d_target     (jump_d_target),
        .redirect_e        (redirect_e),
        .redirect_e_target (redirect_e_target),
        .stall_outer       (stall_outer),
        .flush_F_1         (flush_F_1),
        .flush_F_2         (flush_F_2),
        .flush_D_1         (flush_D_1),
        .flush_D_2         (flush_D_2),
        .pc_en             (pc_en),
        .pc_next           (pc_next),
        .stall_timeout     (stall_timeout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at t=%0t", name, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: bubbles left to discard, consecutive held cycles
    // ------------------------------------------------------------------
    int m_refill_left = 0, m_stall_run = 0;
    int m_refill_nxt  = 0, m_stall_nxt = 0;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_refill_left <= 0;
            m_stall_run   <= 0;
        end else begin
            m_refill_left <= m_refill_nxt;
            m_stall_run   <= m_stall_nxt;
        end
    end

    always @(negedge clk) begin
        bit ev_redir, ev_jump, ev_stall, in_bub, ev_p1, ev_p2;
        bit e_fF1, e_fF2, e_fD1, e_fD2, e_pcen, e_to;
        logic [7:0] e_pc;
        ev_redir = reset && redirect_e;
        ev_jump  = reset && jump_d && !ev_redir;
        in_bub   = (m_refill_left > 0);
        ev_stall = reset && stall_req_d && !ev_redir && !ev_jump && !in_bub;
        ev_p1    = reset && !ev_redir && !ev_jump && !ev_stall && !in_bub && predictionF_1;
        ev_p2    = reset && !ev_redir && !ev_jump && !ev_stall && !in_bub && !predictionF_1 && predictionF_2;

        if (ev_redir)      e_pc = redirect_e_target;
        else if (ev_jump)  e_pc = jump_d_target;
        else if (ev_p1)    e_pc = pcBranchF;
        else if (ev_p2)    e_pc = pcBranchF_inst2;
        else               e_pc = 8'((int'(pcF) + 2) % 256);

        e_fF1  = ev_redir || ev_jump || in_bub;
        e_fF2  = e_fF1 || ev_p1;
        e_fD1  = ev_redir;
        e_fD2  = ev_redir || (ev_jump && !jump_d_slot);
        e_pcen = !ev_stall;
        e_to   = ev_stall && (m_stall_run >= MAXS);

        chk("m_stall_outer", 32'(stall_outer), 32'(ev_stall));
        chk("m_flush_F_1",   32'(flush_F_1),   32'(e_fF1));
        chk("m_flush_F_2",   32'(flush_F_2),   32'(e_fF2));
        chk("m_flush_D_1",   32'(flush_D_1),   32'(e_fD1));
        chk("m_flush_D_2",   32'(flush_D_2),   32'(e_fD2));
        chk("m_pc_en",       32'(pc_en),       32'(e_pcen));
        chk("m_timeout",     32'(stall_timeout), 32'(e_to));
        if (e_pcen) chk("m_pc_next", 32'(pc_next), 32'(e_pc));

        if (!reset)                   m_refill_nxt = 0;
        else if (ev_redir || ev_jump) m_refill_nxt = LAT;
        else if (in_bub)              m_refill_nxt = m_refill_left - 1;
        else                          m_refill_nxt = 0;
        m_stall_nxt = ev_stall ? ((m_stall_run + 1 > MAXS) ? MAXS : m_stall_run + 1) : 0;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // ------------------------------------------------------------------
    // Directed stimulus with literal expectations
    // ------------------------------------------------------------------
    initial begin
        #3;
        chk("rst_pc_en",   32'(pc_en), 32'h1);
        chk("rst_pc_next", 32'(pc_next), 32'h12);
        chk("rst_flushes", 32'({flush_F_1, flush_F_2, flush_D_1, flush_D_2, stall_outer, stall_timeout}), 32'h0);
        #9 reset = 1'b1;
        next_cycle();

        // Sequential fetch and wrap
        pcF = 8'h10; #1;
        chk("seq_pc", 32'(pc_next), 32'h12);
        chk("seq_fl", 32'({flush_F_1, flush_F_2, flush_D_1, flush_D_2}), 32'h0);
        next_cycle();
        pcF = 8'hFF; #1;
        chk("seq_wrap", 32'(pc_next), 32'h01);
        next_cycle();

        // Predictions: slot 1 wins over slot 2
        pcF = 8'h30; predictionF_1 = 1; predictionF_2 = 1;
        pcBranchF = 8'h40; pcBranchF_inst2 = 8'h50; #1;
        chk("p1_pc",  32'(pc_next), 32'h40);
        chk("p1_fF",  32'({flush_F_1, flush_F_2}), 32'b01);
        next_cycle();
        predictionF_1 = 0; #1;
        chk("p2_pc",  32'(pc_next), 32'h50);
        chk("p2_fF2", 32'(flush_F_2), 32'h0);
        next_cycle();
        predictionF_2 = 0;

        // Jump in slot 1, then one refill bubble with a prediction ignored
        jump_d = 1; jump_d_slot = 0; jump_d_target = 8'h20; #1;
        chk("j1_fl", 32'({flush_F_1, flush_F_2, flush_D_1, flush_D_2}), 32'b1101);
        chk("j1_pc", 32'(pc_next), 32'h20);
        next_cycle();
        jump_d = 0; pcF = 8'h20; predictionF_1 = 1; #1;
        chk("j1_bub_fl", 32'({flush_F_1, flush_F_2}), 32'b11);
        chk("j1_bub_pc", 32'(pc_next), 32'h22);
        next_cycle();
        predictionF_1 = 0; #1;
        chk("j1_run_fl", 32'({flush_F_1, flush_F_2}), 32'b00);
        next_cycle();

        // Jump in slot 2 keeps slot 1 in decode
        jump_d = 1; jump_d_slot = 1; jump_d_target = 8'h60; #1;
        chk("j2_fD2", 32'(flush_D_2), 32'h0);
        chk("j2_fF",  32'({flush_F_1, flush_F_2}), 32'b11);
        next_cycle();
        jump_d = 0;
        next_cycle();
        next_cycle();

        // 20-cycle stall with saturation and timeout
        stall_req_d = 1;
        for (int i = 0; i < 20; i++) begin
            #1;
            chk("st_outer", 32'(stall_outer), 32'h1);
            chk("st_pc_en", 32'(pc_en), 32'h0);
            chk("st_to",    32'(stall_timeout), (i >= 15) ? 32'h1 : 32'h0);
            next_cycle();
        end
        stall_req_d = 0; #1;
        chk("st_rel_outer", 32'(stall_outer), 32'h0);
        chk("st_rel_to",    32'(stall_timeout), 32'h0);
        next_cycle();

        // Redirect during stall
        stall_req_d = 1;
        repeat (3) next_cycle();
        redirect_e = 1; redirect_e_target = 8'h80; #1;
        chk("rd_st_outer", 32'(stall_outer), 32'h0);
        chk("rd_st_fl", 32'({flush_F_1, flush_F_2, flush_D_1, flush_D_2}), 32'hF);
        chk("rd_st_pc", 32'(pc_next), 32'h80);
        next_cycle();
        redirect_e = 0; #1;
        chk("rd_bub_outer", 32'(stall_outer), 32'h0);
        chk("rd_bub_fF1",   32'(flush_F_1), 32'h1);
        next_cycle();
        chk("rd_run_outer", 32'(stall_outer), 32'h1);
        stall_req_d = 0;
        next_cycle();

        // Redirect during refill retargets and restarts the bubbles
        redirect_e = 1; redirect_e_target = 8'h30;
        next_cycle();
        redirect_e_target = 8'h31; #1;
        chk("rr_pc", 32'(pc_next), 32'h31);
        next_cycle();
        redirect_e = 0; #1;
        chk("rr_bub", 32'(flush_F_1), 32'h1);
        next_cycle();
        chk("rr_run", 32'(flush_F_1), 32'h0);
        next_cycle();

        // Async reset mid-REFILL
        redirect_e = 1; redirect_e_target = 8'h90;
        next_cycle();
        redirect_e = 0; #1;
        chk("rsr_pre", 32'(flush_F_1), 32'h1);
        #1 reset = 0; #1;
        chk("rsr_fl", 32'({flush_F_1, flush_F_2, flush_D_1, flush_D_2}), 32'h0);
        chk("rsr_pc_en", 32'(pc_en), 32'h1);
        @(posedge clk); #2 reset = 1; #1;
        chk("rsr_post", 32'({flush_F_1, flush_F_2}), 32'h0);
        next_cycle();

        // Async reset mid-STALL clears the stall count
        stall_req_d = 1;
        repeat (17) next_cycle();
        chk("rss_pre_to", 32'(stall_timeout), 32'h1);
        #1 reset = 0; #1;
        chk("rss_outer", 32'(stall_outer), 32'h0);
        chk("rss_to",    32'(stall_timeout), 32'h0);
        @(posedge clk); #2 reset = 1; #1;
        chk("rss_post_outer", 32'(stall_outer), 32'h1);
        chk("rss_post_to",    32'(stall_timeout), 32'h0);
        next_cycle();
        stall_req_d = 0;
        next_cycle();
        next_cycle();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
